// File: rtl/dmem_ctrl.sv
// dmem_ctrl - parametrised data-memory controller between the CPU data port
// and an internal word-addressed RAM, with programmable wait states, byte
// enables, a ready/stall handshake and error reporting.
//
// Ports:
//   inclk   clock, rising edge
//   rstn    asynchronous active-low reset
//   cs      request valid, held by the master until ready
//   rd, wr  read / write request (exactly one must be set)
//   be      write byte enables, bit i covers byte lane i
//   addr    byte address
//   wdata   write data
//   rdata   read data, valid only while ready=1
//   ready   one-cycle completion pulse
//   err     one-cycle error pulse, asserted together with ready
//   stall   cs & ~ready, holds the CPU PC
//
// Optional build macro: DMEM_CTRL_CYCLE_CNT_EN maps a read-only 32-bit
// free-running cycle counter at MMIO_BASE. Without it MMIO_BASE is treated
// as out of range.
//
// The access is committed on the edge that enters ACCESS, so rdata/ready/err
// are registered and visible for the whole ACCESS cycle. ACCESS always
// returns to IDLE, which gives the master that cycle to drop cs.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | waiting for cs; latches the request when cs=1
// WAIT   | counting down programmed wait states
// ACCESS | access done, ready (and err if rejected) high for this cycle

module dmem_ctrl #(
    parameter int          DATA_W      = 32,
    parameter int          DEPTH       = 1024,
    parameter int          WAIT_STATES = 1,
    parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000
) (
    input  logic                inclk,
    input  logic                rstn,
    input  logic                cs,
    input  logic                rd,
    input  logic                wr,
    input  logic [DATA_W/8-1:0] be,
    input  logic [31:0]         addr,
    input  logic [DATA_W-1:0]   wdata,
    output logic [DATA_W-1:0]   rdata,
    output logic                ready,
    output logic                err,
    output logic                stall
);

    localparam int          BYTES      = DATA_W / 8;
    localparam int          OFF_W      = (BYTES > 1) ? $clog2(BYTES) : 0;
    localparam int          IDX_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [31:0] ALIGN_MASK = 32'(BYTES - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    state_t              state;
    logic [3:0]          cnt;
    logic                lat_rd;
    logic                lat_wr;
    logic [BYTES-1:0]    lat_be;
    logic [31:0]         lat_addr;
    logic [DATA_W-1:0]   lat_wdata;

    logic [DATA_W-1:0]   mem [DEPTH];

    // Request seen by the decode: live inputs while IDLE (needed when there
    // are no wait states and the access happens on the accepting edge),
    // otherwise the latched copy.
    logic                req_rd;
    logic                req_wr;
    logic [BYTES-1:0]    req_be;
    logic [31:0]         req_addr;
    logic [DATA_W-1:0]   req_wdata;

    always_comb begin
        req_rd    = lat_rd;
        req_wr    = lat_wr;
        req_be    = lat_be;
        req_addr  = lat_addr;
        req_wdata = lat_wdata;
        if (state == ST_IDLE) begin
            req_rd    = rd;
            req_wr    = wr;
            req_be    = be;
            req_addr  = addr;
            req_wdata = wdata;
        end
    end

    logic [31:0]       word_full;
    logic [IDX_W-1:0]  req_idx;
    logic              bad_cmd;
    logic              misaligned;
    logic              out_range;
    logic              null_wr;
    logic              mmio_hit;
    logic              acc_err;
    logic [DATA_W-1:0] acc_rdata;
    logic              do_access;
    logic              mem_we;

    assign word_full  = req_addr >> OFF_W;
    assign req_idx    = req_addr[OFF_W +: IDX_W];
    assign bad_cmd    = (req_rd == req_wr);
    assign misaligned = (req_addr & ALIGN_MASK) != 32'd0;
    assign out_range  = (word_full >= 32'(DEPTH));
    assign null_wr    = req_wr & ~(|req_be);
    assign mmio_hit   = (req_addr == MMIO_BASE);

`ifdef DMEM_CTRL_CYCLE_CNT_EN
    logic [31:0] cyc_cnt;
    logic        mmio_rd_ok;

    always_ff @(posedge inclk or negedge rstn) begin
        if (!rstn) begin
            cyc_cnt <= 32'd0;
        end else begin
            cyc_cnt <= cyc_cnt + 32'd1;
        end
    end

    // Only a clean read of MMIO_BASE escapes the out-of-range error;
    // writes there still fall through to err.
    assign mmio_rd_ok = mmio_hit & req_rd & ~req_wr;
    assign acc_err    = bad_cmd | misaligned | null_wr | (out_range & ~mmio_rd_ok);

    always_comb begin
        acc_rdata = '0;
        if (!acc_err && req_rd) begin
            acc_rdata = mmio_rd_ok ? DATA_W'(cyc_cnt) : mem[req_idx];
        end
    end
`else
    assign acc_err = bad_cmd | misaligned | null_wr | out_range | mmio_hit;

    always_comb begin
        acc_rdata = '0;
        if (!acc_err && req_rd) begin
            acc_rdata = mem[req_idx];
        end
    end
`endif

    assign do_access = ((state == ST_IDLE) && cs && (WAIT_STATES == 0)) ||
                       ((state == ST_WAIT) && (cnt <= 4'd1));

    // rstn gating keeps a pending write out of the RAM while in reset.
    assign mem_we = do_access & rstn & req_wr & ~acc_err;

    always_ff @(posedge inclk) begin
        if (mem_we) begin
            for (int i = 0; i < BYTES; i++) begin
                if (req_be[i]) begin
                    mem[req_idx][i*8 +: 8] <= req_wdata[i*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge inclk or negedge rstn) begin
        if (!rstn) begin
            state     <= ST_IDLE;
            cnt       <= 4'd0;
            rdata     <= '0;
            ready     <= 1'b0;
            err       <= 1'b0;
            lat_rd    <= 1'b0;
            lat_wr    <= 1'b0;
            lat_be    <= '0;
            lat_addr  <= 32'd0;
            lat_wdata <= '0;
        end else begin
            ready <= 1'b0;
            err   <= 1'b0;
            rdata <= '0;
            case (state)
                ST_IDLE: begin
                    if (cs) begin
                        lat_rd    <= rd;
                        lat_wr    <= wr;
                        lat_be    <= be;
                        lat_addr  <= addr;
                        lat_wdata <= wdata;
                        cnt       <= 4'(WAIT_STATES);
                        if (WAIT_STATES == 0) begin
                            state <= ST_ACCESS;
                            ready <= 1'b1;
                            err   <= acc_err;
                            rdata <= acc_rdata;
                        end else begin
                            state <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt <= 4'd1) begin
                        state <= ST_ACCESS;
                        ready <= 1'b1;
                        err   <= acc_err;
                        rdata <= acc_rdata;
                    end
                end
                ST_ACCESS: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign stall = cs & ~ready;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Testbench for dmem_ctrl: three instances (1, 0 and 3 wait states) against
// a word-array reference model, a table of directed vectors, hand-written
// multi-cycle sequences and randomized transactions.

module tb_dmem_ctrl;

    localparam int          DW   = 32;
    localparam int          DEP  = 64;
    localparam logic [31:0] MMIO = 32'hFFFF_0000;

    logic            clk = 1'b0;
    logic            rstn = 1'b0;
    logic            rd = 1'b0;
    logic            wr = 1'b0;
    logic [3:0]      be = 4'h0;
    logic [31:0]     addr = 32'd0;
    logic [31:0]     wdata = 32'd0;
    logic [2:0]      cs_v = 3'b000;
    logic [2:0][31:0] rdata_v;
    logic [2:0]      ready_v;
    logic [2:0]      err_v;
    logic [2:0]      stall_v;

    int n_vec = 0;
    int n_bad = 0;
    int unsigned tb_cyc = 0;

    logic [31:0] mdl [3][DEP];

    always #5 clk = ~clk;
    always @(posedge clk) tb_cyc <= tb_cyc + 1;

    dmem_ctrl #(.DATA_W(DW), .DEPTH(DEP), .WAIT_STATES(1), .MMIO_BASE(MMIO)) u_ws1 (
        .inclk(clk), .rstn(rstn), .cs(cs_v[0]), .rd(rd), .wr(wr), .be(be),
        .addr(addr), .wdata(wdata), .rdata(rdata_v[0]), .ready(ready_v[0]),
        .err(err_v[0]), .stall(stall_v[0])
    );

    dmem_ctrl #(.DATA_W(DW), .DEPTH(DEP), .WAIT_STATES(0), .MMIO_BASE(MMIO)) u_ws0 (
        .inclk(clk), .rstn(rstn), .cs(cs_v[1]), .rd(rd), .wr(wr), .be(be),
        .addr(addr), .wdata(wdata), .rdata(rdata_v[1]), .ready(ready_v[1]),
        .err(err_v[1]), .stall(stall_v[1])
    );

    dmem_ctrl #(.DATA_W(DW), .DEPTH(DEP), .WAIT_STATES(3), .MMIO_BASE(MMIO)) u_ws3 (
        .inclk(clk), .rstn(rstn), .cs(cs_v[2]), .rd(rd), .wr(wr), .be(be),
        .addr(addr), .wdata(wdata), .rdata(rdata_v[2]), .ready(ready_v[2]),
        .err(err_v[2]), .stall(stall_v[2])
    );

    function automatic int ws_of(input int inst);
        case (inst)
            0:       return 1;
            1:       return 0;
            default: return 3;
        endcase
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    // Reference error rules, written directly from the access rules.
    function automatic logic model_err(input logic r, input logic w, input logic [3:0] b,
                                       input logic [31:0] a);
        if (r == w) return 1'b1;
        if ((a % 4) != 0) return 1'b1;
        if (w && b == 4'h0) return 1'b1;
        if ((a / 4) < DEP) return 1'b0;
`ifdef DMEM_CTRL_CYCLE_CNT_EN
        if (a == MMIO && r) return 1'b0;
`endif
        return 1'b1;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] b);
        logic [31:0] mask;
        mask = {{8{b[3]}}, {8{b[2]}}, {8{b[1]}}, {8{b[0]}}};
        return (old & ~mask) | (d & mask);
    endfunction

    // Called #1 after a rising edge. Holds cs until ready, keeps it through
    // the ready cycle, then drops it for one idle cycle.
    task automatic txn(input int inst, input logic r, input logic w, input logic [3:0] b,
                       input logic [31:0] a, input logic [31:0] d,
                       output logic [31:0] got_rd, output logic got_err,
                       output int lat, output int unsigned issue_cyc);
        bit done;
        done      = 0;
        lat       = -1;
        got_rd    = 32'd0;
        got_err   = 1'b0;
        rd        = r;
        wr        = w;
        be        = b;
        addr      = a;
        wdata     = d;
        cs_v[inst] = 1'b1;
        issue_cyc = tb_cyc;
        for (int k = 1; k <= 40 && !done; k++) begin
            @(posedge clk); #1;
            if (ready_v[inst]) begin
                done    = 1;
                lat     = k;
                got_rd  = rdata_v[inst];
                got_err = err_v[inst];
                check("stall_ready_cycle", 32'(stall_v[inst]), 32'd0);
            end else begin
                check("stall_waiting", 32'(stall_v[inst]), 32'd1);
            end
        end
        if (!done) check("ready_timeout", 32'd0, 32'd1);
        rd = $urandom_range(0, 1);
        wr = $urandom_range(0, 1);
        addr = $urandom;
        wdata = $urandom;
        @(posedge clk); #1;
        check("ready_single_pulse", 32'(ready_v[inst]), 32'd0);
        cs_v[inst] = 1'b0;
        rd = 1'b0;
        wr = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic run_chk(input string nm, input int inst, input logic r, input logic w,
                           input logic [3:0] b, input logic [31:0] a, input logic [31:0] d);
        logic [31:0] got_rd, exp_rd;
        logic        got_err, exp_err;
        int          lat;
        int unsigned ic;
        exp_err = model_err(r, w, b, a);
        exp_rd  = (!exp_err && r) ? mdl[inst][a / 4] : 32'd0;
        txn(inst, r, w, b, a, d, got_rd, got_err, lat, ic);
        check({nm, "_rdata"}, got_rd, exp_rd);
        check({nm, "_err"}, 32'(got_err), 32'(exp_err));
        check({nm, "_latency"}, 32'(lat), 32'(ws_of(inst) + 1));
        if (!exp_err && w) mdl[inst][a / 4] = merge(mdl[inst][a / 4], d, b);
    endtask

    typedef struct {
        string       nm;
        logic        r;
        logic        w;
        logic [3:0]  b;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t tbl [13];

    initial begin
        logic [31:0] got_rd, r1, r2;
        logic        got_err, e1, e2;
        int          lat;
        int unsigned i1, i2;

        tbl[0]  = '{"wr_deadbeef",   1'b0, 1'b1, 4'hF, 32'h10,  32'hDEADBEEF, 32'h0,        1'b0};
        tbl[1]  = '{"rd_deadbeef",   1'b1, 1'b0, 4'hF, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0};
        tbl[2]  = '{"wr_11223344",   1'b0, 1'b1, 4'hF, 32'h10,  32'h11223344, 32'h0,        1'b0};
        tbl[3]  = '{"wr_be0101",     1'b0, 1'b1, 4'h5, 32'h10,  32'hAABBCCDD, 32'h0,        1'b0};
        tbl[4]  = '{"rd_merged",     1'b1, 1'b0, 4'h0, 32'h10,  32'h0,        32'h11BB33DD, 1'b0};
        tbl[5]  = '{"rd_misaligned", 1'b1, 1'b0, 4'hF, 32'h13,  32'h0,        32'h0,        1'b1};
        tbl[6]  = '{"rd_out_range",  1'b1, 1'b0, 4'hF, 32'(DEP*4), 32'h0,     32'h0,        1'b1};
        tbl[7]  = '{"rd_wr_both",    1'b1, 1'b1, 4'hF, 32'h10,  32'h0,        32'h0,        1'b1};
        tbl[8]  = '{"rd_wr_none",    1'b0, 1'b0, 4'hF, 32'h10,  32'h0,        32'h0,        1'b1};
        tbl[9]  = '{"wr_null_be",    1'b0, 1'b1, 4'h0, 32'h10,  32'hFFFFFFFF, 32'h0,        1'b1};
        tbl[10] = '{"wr_misaligned", 1'b0, 1'b1, 4'hF, 32'h12,  32'h0,        32'h0,        1'b1};
        tbl[11] = '{"rd_unchanged",  1'b1, 1'b0, 4'hF, 32'h10,  32'h0,        32'h11BB33DD, 1'b0};
        tbl[12] = '{"wr_mmio",       1'b0, 1'b1, 4'hF, MMIO,    32'h12345678, 32'h0,        1'b1};

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            check("rst_rdata", rdata_v[i], 32'd0);
            check("rst_ready", 32'(ready_v[i]), 32'd0);
            check("rst_err", 32'(err_v[i]), 32'd0);
        end
        rstn = 1'b1;
        @(posedge clk); #1;

        // Directed table on the 1-wait-state instance
        for (int i = 0; i < 13; i++) begin
            txn(0, tbl[i].r, tbl[i].w, tbl[i].b, tbl[i].a, tbl[i].d, got_rd, got_err, lat, i1);
            check({tbl[i].nm, "_rdata"}, got_rd, tbl[i].exp_rd);
            check({tbl[i].nm, "_err"}, 32'(got_err), 32'(tbl[i].exp_err));
            check({tbl[i].nm, "_latency"}, 32'(lat), 32'd2);
        end
        mdl[0][4] = 32'h11BB33DD;

        // Fill the rest of instance 0 so random reads hit known data
        for (int i = 0; i < DEP; i++) begin
            if (i != 4) run_chk("init", 0, 1'b0, 1'b1, 4'hF, 32'(i * 4), $urandom);
        end

        // Zero wait states: back-to-back writes then read-back
        run_chk("ws0_wr0", 1, 1'b0, 1'b1, 4'hF, 32'h0, 32'hA5A5_0001);
        run_chk("ws0_wr4", 1, 1'b0, 1'b1, 4'hF, 32'h4, 32'h5A5A_0002);
        run_chk("ws0_rd0", 1, 1'b1, 1'b0, 4'hF, 32'h0, 32'h0);
        run_chk("ws0_rd4", 1, 1'b1, 1'b0, 4'hF, 32'h4, 32'h0);
        check("ws0_model_w0", mdl[1][0], 32'hA5A5_0001);

        // Reset during WAIT on the 3-wait-state instance
        run_chk("ws3_prior", 2, 1'b0, 1'b1, 4'hF, 32'h20, 32'hCAFE_F00D);
        rd = 1'b0; wr = 1'b1; be = 4'hF; addr = 32'h20; wdata = 32'h55;
        cs_v[2] = 1'b1;
        @(posedge clk); #1;
        check("ws3_ready_in_wait", 32'(ready_v[2]), 32'd0);
        @(posedge clk); #1;
        rstn = 1'b0;
        #1;
        check("midrst_ready", 32'(ready_v[2]), 32'd0);
        check("midrst_err", 32'(err_v[2]), 32'd0);
        check("midrst_rdata", rdata_v[2], 32'd0);
        repeat (3) begin
            @(posedge clk); #1;
            check("midrst_no_ready", 32'(ready_v[2]), 32'd0);
        end
        cs_v[2] = 1'b0;
        wr = 1'b0;
        rstn = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
            check("postrst_no_ready", 32'(ready_v[2]), 32'd0);
        end
        run_chk("ws3_kept", 2, 1'b1, 1'b0, 4'hF, 32'h20, 32'h0);

        // MMIO cycle counter reads issued 10 cycles apart
        txn(0, 1'b1, 1'b0, 4'hF, MMIO, 32'h0, r1, e1, lat, i1);
        while (tb_cyc < i1 + 10) begin
            @(posedge clk); #1;
        end
        txn(0, 1'b1, 1'b0, 4'hF, MMIO, 32'h0, r2, e2, lat, i2);
        check("mmio_latency", 32'(lat), 32'd2);
`ifdef DMEM_CTRL_CYCLE_CNT_EN
        check("mmio_err1", 32'(e1), 32'd0);
        check("mmio_err2", 32'(e2), 32'd0);
        check("mmio_delta", r2 - r1, 32'd10);
`else
        check("mmio_err1", 32'(e1), 32'd1);
        check("mmio_err2", 32'(e2), 32'd1);
        check("mmio_rdata1", r1, 32'd0);
        check("mmio_rdata2", r2, 32'd0);
`endif

        // Randomized traffic on instance 0
        for (int n = 0; n < 300; n++) begin
            logic        r, w;
            logic [3:0]  b;
            logic [31:0] a;
            int          kind;
            kind = $urandom_range(0, 11);
            r    = 1'($urandom_range(0, 1));
            w    = ~r;
            if (kind == 3) w = r;
            b    = 4'($urandom);
            a    = 32'($urandom_range(0, DEP - 1) * 4);
            if (kind == 0) a = a + 32'($urandom_range(1, 3));
            if (kind == 1) a = 32'($urandom_range(DEP, 4000) * 4);
            if (kind == 2) begin
                a = MMIO;
                r = 1'b0;
                w = 1'b1;
            end
            run_chk("rand", 0, r, w, b, a, $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog");
    end

endmodule
